// File: rtl/riscv_if.sv
`timescale 1ns/1ps
// Instruction fetch front end: credit-limited request issue toward imem, in-order
// response buffering toward decode, redirect flush with in-flight drop counting.
//
// state | meaning
// RUN   | fetching normally, requests issued while credit allows
// HALT  | misaligned redirect seen; no requests, exception held, responses drained
module riscv_if #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            valid,
  input  logic            ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic            exception
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t          state;
  logic            exc_q;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [XLEN-1:0] buf_instr [DEPTH];
  logic [XLEN-1:0] buf_pc    [DEPTH];

  logic [CW:0] credit_used;
  logic        req_ok;
  logic        gnt_fire;
  logic        rsp_fire;
  logic        push;
  logic        pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Buffered entries plus in-flight requests never exceed DEPTH, so a push always has room.
  assign credit_used = {1'b0, outstanding} + {1'b0, count};
  assign req_ok      = (state == RUN) && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_req    = rst_n && req_ok;
  assign imem_addr   = fetch_pc;

  assign gnt_fire = imem_req && imem_gnt;
  assign rsp_fire = imem_rvalid && (outstanding != '0);
  assign push     = rsp_fire && (drop == '0) && !redirect && (state == RUN);
  assign pop      = valid && ready && !redirect;

  assign valid       = (count != '0);
  assign instruction = buf_instr[head];
  assign pc          = buf_pc[head];
  assign exception   = exc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      exc_q <= 1'b0;
    end else if (redirect) begin
      if (redirect_pc[1:0] != 2'b00) begin
        state <= HALT;
        exc_q <= 1'b1;
      end else begin
        state <= RUN;
        exc_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else begin
      outstanding <= outstanding + CW'(gnt_fire) - CW'(rsp_fire);
      if (gnt_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
      if (redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop     <= outstanding - CW'(rsp_fire);
        count    <= '0;
        head     <= '0;
        tail     <= '0;
      end else begin
        if (rsp_fire && (drop != '0)) begin
          drop <= drop - 1'b1;
        end
        if (push) begin
          rsp_pc <= rsp_pc + XLEN'(4);
          tail   <= ptr_inc(tail);
        end
        if (pop) begin
          head <= ptr_inc(head);
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[tail] <= imem_rdata;
      buf_pc[tail]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_riscv_if.sv
`timescale 1ns/1ps
// Directed bench for riscv_if: behavioral imem with one-cycle response latency,
// a per-cycle vector table after reset and hand sequences for redirect/halt/reset cases.
module tb_riscv_if;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        exception;

  riscv_if #(.XLEN(32), .RESET_PC(RPC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .valid(valid), .ready(ready), .instruction(instruction), .pc(pc),
    .exception(exception)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nfail = 0;
  int          gcnt = 0;
  logic [31:0] exp_pc;
  logic [31:0] gq[$];
  logic        stall = 1'b0;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] vpc;
  } vec_t;
  vec_t tbl[6];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // imem: grants are recorded at the clock edge, answered in order one cycle later.
  always @(posedge clk) begin
    if (rst_n && imem_req && imem_gnt) begin
      gq.push_back(imem_addr);
      gcnt <= gcnt + 1;
    end
  end

  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!stall && gq.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(gq.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Checks any transfer happening at the coming edge, then moves to the next drive point.
  task automatic tick();
    if (rst_n && valid && ready && !redirect) begin
      chk("xfer_pc", pc, exp_pc);
      chk("xfer_instr", instruction, word_of(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    @(negedge clk);
    #2;
    redirect = 1'b0;
  endtask

  task automatic wait_valid(input int max, input logic [31:0] want, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      #1;
      if (valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) #1;
    chk({name, "_seen"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      chk({name, "_pc"}, pc, want);
      chk({name, "_instr"}, instruction, word_of(want));
    end
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      tick();
    end
  endtask

  initial begin
    logic [31:0] ga[2];
    int          na;
    int          g0;

    tbl[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    tbl[4] = '{1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008};

    ready       = 1'b0;
    imem_gnt    = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    exp_pc      = RPC;
    @(negedge clk);
    #2;

    // reset values and streaming start
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_exc", {31'd0, exception}, 32'd0);
    chk("rst_addr", imem_addr, RPC);
    tick();
    rst_n  = 1'b1;
    exp_pc = RPC;
    for (int i = 0; i < 6; i++) begin
      ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].vld});
      if (tbl[i].vld) chk($sformatf("tbl%0d_pc", i), pc, tbl[i].vpc);
      tick();
    end
    stream(12);

    // backpressure from reset: two grants fill the buffer, head held
    rst_n = 1'b0;
    ready = 1'b0;
    gq.delete();
    stream(2);
    rst_n  = 1'b1;
    exp_pc = RPC;
    g0     = gcnt;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (i < 2) begin
        chk("bp_req_early", {31'd0, imem_req}, 32'd1);
      end else begin
        chk("bp_req_full", {31'd0, imem_req}, 32'd0);
        chk("bp_valid", {31'd0, valid}, 32'd1);
        chk("bp_pc", pc, RPC);
        chk("bp_instr", instruction, word_of(RPC));
      end
      tick();
    end
    chk("bp_grants", gcnt - g0, 32'd2);
    ready = 1'b1;
    #1;
    chk("bp_rel0_pc", pc, RPC);
    chk("bp_rel0_req", {31'd0, imem_req}, 32'd0);
    tick();
    #1;
    chk("bp_rel1_valid", {31'd0, valid}, 32'd1);
    chk("bp_rel1_pc", pc, RPC + 32'd4);
    chk("bp_rel1_req", {31'd0, imem_req}, 32'd1);
    tick();
    stream(6);

    // aligned redirect with two requests in flight
    stall = 1'b1;
    stream(6);
    #1;
    chk("st_req", {31'd0, imem_req}, 32'd0);
    chk("st_valid", {31'd0, valid}, 32'd0);
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    stall       = 1'b0;
    #1;
    chk("rd_req_same", {31'd0, imem_req}, 32'd0);
    exp_pc = 32'h0000_0100;
    tick();
    #1;
    chk("rd_addr1", imem_addr, 32'h0000_0100);
    chk("rd_req1", {31'd0, imem_req}, 32'd0);
    chk("rd_valid1", {31'd0, valid}, 32'd0);
    tick();
    #1;
    chk("rd_req2", {31'd0, imem_req}, 32'd1);
    chk("rd_addr2", imem_addr, 32'h0000_0100);
    chk("rd_valid2", {31'd0, valid}, 32'd0);
    tick();
    wait_valid(8, 32'h0000_0100, "rd");
    tick();
    stream(6);

    // misaligned redirect halts, aligned redirect resumes
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1;
    chk("mis_req_same", {31'd0, imem_req}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("halt_exc", {31'd0, exception}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, valid}, 32'd0);
      tick();
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    chk("unhalt_exc_same", {31'd0, exception}, 32'd1);
    chk("unhalt_req_same", {31'd0, imem_req}, 32'd0);
    exp_pc = 32'h0000_0200;
    tick();
    #1;
    chk("unhalt_exc", {31'd0, exception}, 32'd0);
    chk("unhalt_addr", imem_addr, 32'h0000_0200);
    chk("unhalt_req", {31'd0, imem_req}, 32'd1);
    tick();
    wait_valid(8, 32'h0000_0200, "unhalt");
    tick();
    stream(4);

    // address wrap at the top of the space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_pc      = 32'hFFFF_FFFC;
    #1;
    tick();
    ga[0] = 32'hDEAD_DEAD;
    ga[1] = 32'hDEAD_DEAD;
    na    = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (imem_req && imem_gnt && na < 2) begin
        ga[na] = imem_addr;
        na++;
      end
      tick();
    end
    chk("wrap_n", na, 32'd2);
    chk("wrap_a0", ga[0], 32'hFFFF_FFFC);
    chk("wrap_a1", ga[1], 32'h0000_0000);
    stream(4);

    // reset with two requests in flight; late responses must be ignored
    stall = 1'b1;
    stream(6);
    #1;
    chk("pre_rst_req", {31'd0, imem_req}, 32'd0);
    rst_n    = 1'b0;
    imem_gnt = 1'b0;
    tick();
    #1;
    chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_exc", {31'd0, exception}, 32'd0);
    chk("mid_rst_addr", imem_addr, RPC);
    tick();
    rst_n = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("late_valid", {31'd0, valid}, 32'd0);
      chk("late_req", {31'd0, imem_req}, 32'd1);
      chk("late_addr", imem_addr, RPC);
      tick();
    end
    imem_gnt = 1'b1;
    exp_pc   = RPC;
    wait_valid(8, RPC, "post_rst");
    tick();
    stream(4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
